// File: rtl/dd_pkg.sv
// Shared constants and FSM state type for the FX3 read-side sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dd_pkg;

    // One burst is one buffer half and one 16 KB FX3 endpoint (8192 x 16-bit words).
    localparam int BURST_WORDS  = 8192;
    // Cycles from a buffer read request to valid read data (normal-mode FIFO).
    localparam int FIFO_LATENCY = 1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_DATA = 3'd1,
        STREAM    = 3'd2,
        FLUSH     = 3'd3,
        GAP       = 3'd4
    } ctrlState_t;

    // Bits needed to hold the values 0..maxValue.
    function automatic int counterWidth(input int maxValue);
        return (maxValue < 1) ? 1 : $clog2(maxValue + 1);
    endfunction

endpackage

// File: rtl/signal_sync.sv
// Two-flop synchroniser for a slow level flag, plus a one-cycle rising-edge pulse.
// Latency: level visible 2 clocks after it settles; pulse fires in the 3rd clock.
// Backpressure: none; the source must hold each level for more than two clocks.
//
// Ports:
//   clock      in   destination-domain clock
//   reset      in   synchronous, active-high; clears all three flops
//   asyncIn    in   flag from another clock domain
//   risePulse  out  one-cycle pulse per synchronised 0->1 transition
module signal_sync (
    input  logic clock,
    input  logic reset,
    input  logic asyncIn,
    output logic risePulse
);

    logic metaStage;
    logic syncStage;
    logic syncPrev;

    always_ff @(posedge clock) begin
        if (reset) begin
            metaStage <= 1'b0;
            syncStage <= 1'b0;
            syncPrev  <= 1'b0;
        end else begin
            metaStage <= asyncIn;
            syncStage <= metaStage;
            syncPrev  <= syncStage;
        end
    end

    // Edge detect on the already-synchronised level, never on metaStage.
    assign risePulse = syncStage & ~syncPrev;

endmodule

// File: rtl/fx3_burst_controller.sv
// Streams one BURST_WORDS burst per full buffer half into the FX3 slave FIFO; latches overflow errors.
// Latency: fx3Write/fx3PacketEnd trail isReading by FIFO_LATENCY cycles; fx3Data is combinational from dataIn.
// Backpressure: fx3Ready=0 drops isReading in the same cycle; up to FIFO_LATENCY in-flight words still land.
//
// Ports:
//   readClock       in   sole clock (buffer read clock and FX3 PCLK)
//   reset           in   synchronous, active-high
//   collectData     in   host capture enable; its rising edge clears the counters and sticky flag
//   dataAvailable   in   buffer has a full half ready
//   bufferOverflow  in   buffer overflow flag, asynchronous to readClock
//   fx3Ready        in   FX3 endpoint can accept data
//   dataIn          in   buffer read data, valid FIFO_LATENCY cycles after isReading
//   isReading       out  buffer read request (only ever high in STREAM)
//   fx3Write        out  write strobe to FX3
//   fx3Data         out  data to FX3
//   fx3PacketEnd    out  high with the last word of each burst
//   busy            out  high in every state except IDLE
//   overflowSticky  out  latched overflow error
//   burstCount      out  completed bursts since capture start, wraps
//   overflowCount   out  overflow events since capture start, saturates
module fx3_burst_controller #(
    parameter int BURST_WORDS  = dd_pkg::BURST_WORDS,
    parameter int FIFO_LATENCY = dd_pkg::FIFO_LATENCY,
    parameter int GAP_CYCLES   = 4,
    parameter int COUNT_WIDTH  = 16
) (
    input  logic                   readClock,
    input  logic                   reset,
    input  logic                   collectData,
    input  logic                   dataAvailable,
    input  logic                   bufferOverflow,
    input  logic                   fx3Ready,
    input  logic [15:0]            dataIn,
    output logic                   isReading,
    output logic                   fx3Write,
    output logic [15:0]            fx3Data,
    output logic                   fx3PacketEnd,
    output logic                   busy,
    output logic                   overflowSticky,
    output logic [COUNT_WIDTH-1:0] burstCount,
    output logic [COUNT_WIDTH-1:0] overflowCount
);

    import dd_pkg::*;

    // The issue counter must be able to hold BURST_WORDS itself, hence the extra bit.
    localparam int ISSUE_W   = $clog2(BURST_WORDS) + 1;
    localparam int PHASE_MAX = (GAP_CYCLES > FIFO_LATENCY) ? GAP_CYCLES : FIFO_LATENCY;
    localparam int PHASE_W   = counterWidth(PHASE_MAX);

    localparam logic [ISSUE_W-1:0]     ISSUE_LIMIT = ISSUE_W'(BURST_WORDS);
    localparam logic [ISSUE_W-1:0]     LAST_ISSUE  = ISSUE_W'(BURST_WORDS - 1);
    localparam logic [PHASE_W-1:0]     FLUSH_LAST  = PHASE_W'(FIFO_LATENCY - 1);
    localparam logic [PHASE_W-1:0]     GAP_LAST    = PHASE_W'(GAP_CYCLES - 1);
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX   = '1;

    ctrlState_t             state;
    ctrlState_t             nextState;
    logic [ISSUE_W-1:0]     issued;
    logic [PHASE_W-1:0]     phaseCount;
    logic                   lastIssue;
    logic                   flushDone;
    logic                   gapDone;
    logic                   collectPrev;
    logic                   collectRise;
    logic                   overflowRise;
    logic [FIFO_LATENCY-1:0] writePipe;
    logic [FIFO_LATENCY-1:0] endPipe;

    //------------------------------------------------------------------
    // FSM: state register
    //------------------------------------------------------------------
    always_ff @(posedge readClock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    //------------------------------------------------------------------
    // FSM: next-state logic
    //------------------------------------------------------------------
    always_comb begin
        nextState = state;
        unique case (state)
            IDLE: begin
                if (collectData) nextState = WAIT_DATA;
            end
            WAIT_DATA: begin
                if (!collectData)      nextState = IDLE;
                else if (dataAvailable) nextState = STREAM;
            end
            STREAM: begin
                // Leave on the cycle that issues the last word, so issued reaches
                // BURST_WORDS on the same edge that enters FLUSH. collectData is
                // deliberately ignored here: a started burst always completes.
                if (lastIssue) nextState = FLUSH;
            end
            FLUSH: begin
                if (flushDone) nextState = GAP;
            end
            GAP: begin
                if (gapDone) nextState = collectData ? WAIT_DATA : IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    //------------------------------------------------------------------
    // FSM: outputs
    //------------------------------------------------------------------
    always_comb begin
        isReading = 1'b0;
        busy      = 1'b1;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
            end
            STREAM: begin
                // Combinational on fx3Ready so back-pressure stops the read the
                // same cycle; the FX3 watermark absorbs the words already in flight.
                isReading = fx3Ready && (issued < ISSUE_LIMIT);
            end
            default: begin
            end
        endcase
    end

    assign lastIssue = isReading && (issued == LAST_ISSUE);
    assign flushDone = (state == FLUSH) && (phaseCount == FLUSH_LAST);
    assign gapDone   = (state == GAP)   && (phaseCount == GAP_LAST);

    //------------------------------------------------------------------
    // Words requested from the buffer in the current burst
    //------------------------------------------------------------------
    always_ff @(posedge readClock) begin
        if (reset) begin
            issued <= '0;
        end else if (state != STREAM) begin
            issued <= '0;
        end else if (isReading) begin
            issued <= issued + ISSUE_W'(1);
        end
    end

    //------------------------------------------------------------------
    // Dwell counter shared by FLUSH and GAP; restarts on every state change
    //------------------------------------------------------------------
    always_ff @(posedge readClock) begin
        if (reset) begin
            phaseCount <= '0;
        end else if (nextState != state) begin
            phaseCount <= '0;
        end else if ((state == FLUSH) || (state == GAP)) begin
            phaseCount <= phaseCount + PHASE_W'(1);
        end
    end

    //------------------------------------------------------------------
    // Align the write strobe and packet-end marker with the read data
    //------------------------------------------------------------------
    always_ff @(posedge readClock) begin
        if (reset) begin
            writePipe <= '0;
            endPipe   <= '0;
        end else begin
            writePipe[0] <= isReading;
            endPipe[0]   <= lastIssue;
            for (int i = 1; i < FIFO_LATENCY; i++) begin
                writePipe[i] <= writePipe[i-1];
                endPipe[i]   <= endPipe[i-1];
            end
        end
    end

    assign fx3Write     = writePipe[FIFO_LATENCY-1];
    assign fx3PacketEnd = endPipe[FIFO_LATENCY-1];
    assign fx3Data      = dataIn;

    //------------------------------------------------------------------
    // Overflow flag crossing from the write-clock domain
    //------------------------------------------------------------------
    signal_sync overflowSync (
        .clock     (readClock),
        .reset     (reset),
        .asyncIn   (bufferOverflow),
        .risePulse (overflowRise)
    );

    //------------------------------------------------------------------
    // Host-visible status. A new capture (collectData rising) clears
    // everything and takes priority over a coincident overflow or burst end.
    //------------------------------------------------------------------
    assign collectRise = collectData && !collectPrev;

    always_ff @(posedge readClock) begin
        if (reset) begin
            collectPrev    <= 1'b0;
            burstCount     <= '0;
            overflowCount  <= '0;
            overflowSticky <= 1'b0;
        end else begin
            collectPrev <= collectData;
            if (collectRise) begin
                burstCount     <= '0;
                overflowCount  <= '0;
                overflowSticky <= 1'b0;
            end else begin
                if (flushDone) begin
                    burstCount <= burstCount + COUNT_WIDTH'(1);
                end
                if (overflowRise) begin
                    overflowSticky <= 1'b1;
                    if (overflowCount != COUNT_MAX) begin
                        overflowCount <= overflowCount + COUNT_WIDTH'(1);
                    end
                end
            end
        end
    end

endmodule
